// File: rtl/sequenciador_leds.sv
// LED sequence player: shows memory positions 0..rodada on the LEDs,
// each lit for T_ACESO cycles followed by a T_APAGADO dark gap.
module sequenciador_leds #(
    parameter int T_ACESO   = 1000,
    parameter int T_APAGADO = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] rodada,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ativo,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        PREPARA = 4'd1,
        ACENDE  = 4'd2,
        APAGA   = 4'd3,
        PROXIMO = 4'd4,
        FIM     = 4'd5
    } estado_t;

    localparam logic [15:0] LIM_ACESO   = 16'(T_ACESO - 1);
    localparam logic [15:0] LIM_APAGADO = 16'(T_APAGADO - 1);

    estado_t     estado;
    estado_t     proximo;
    logic [15:0] timer;
    logic [3:0]  rodada_reg;
    logic        fim_aceso;
    logic        fim_apagado;
    logic        ultimo;

    assign fim_aceso   = (timer == LIM_ACESO);
    assign fim_apagado = (timer == LIM_APAGADO);
    assign ultimo      = (endereco == rodada_reg);
    assign db_estado   = estado;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    // Next-state and output decode
    always_comb begin
        proximo = estado;
        leds    = 4'd0;
        pronto  = 1'b0;
        ativo   = 1'b1;
        case (estado)
            INICIAL: begin
                ativo = 1'b0;
                if (iniciar) begin
                    proximo = PREPARA;
                end
            end
            PREPARA: proximo = ACENDE;
            ACENDE: begin
                leds = dado;
                if (fim_aceso) begin
                    proximo = APAGA;
                end
            end
            APAGA: begin
                if (fim_apagado) begin
                    proximo = ultimo ? FIM : PROXIMO;
                end
            end
            PROXIMO: proximo = ACENDE;
            FIM: begin
                pronto  = 1'b1;
                proximo = INICIAL;
            end
            default: proximo = INICIAL;
        endcase
    end

    // Timer, address counter and latched sequence length
    always_ff @(posedge clock) begin
        if (reset) begin
            timer      <= 16'd0;
            endereco   <= 4'd0;
            rodada_reg <= 4'd0;
        end else begin
            case (estado)
                INICIAL: begin
                    timer    <= 16'd0;
                    endereco <= 4'd0;
                    if (iniciar) begin
                        rodada_reg <= rodada;
                    end
                end
                PREPARA: begin
                    timer    <= 16'd0;
                    endereco <= 4'd0;
                end
                ACENDE: begin
                    timer <= fim_aceso ? 16'd0 : timer + 16'd1;
                end
                APAGA: begin
                    timer <= fim_apagado ? 16'd0 : timer + 16'd1;
                end
                PROXIMO: begin
                    timer    <= 16'd0;
                    endereco <= endereco + 4'd1;
                end
                FIM: begin
                    timer    <= 16'd0;
                    endereco <= 4'd0;
                end
                default: begin
                    timer    <= 16'd0;
                    endereco <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/sequenciador_leds.md
SEQUENCIADOR_LEDS -- requirements
Module: sequenciador_leds

Interface
REQ-001 Parameter T_ACESO, default 1000, clock cycles each sequence LED is lit (1..65535).
REQ-002 Parameter T_APAGADO, default 500, clock cycles of dark gap after each LED (1..65535).
REQ-003 Port clock  in  1  single system clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port iniciar  in  1  start request, sampled only in state INICIAL.
REQ-006 Port rodada  in  4  index of last memory position to show (sequence length = rodada+1).
REQ-007 Port dado  in  4  memory read data for address endereco, valid in the same cycle (combinational read).
REQ-008 Port endereco  out  4  memory address being shown.
REQ-009 Port leds  out  4  LED drive pattern.
REQ-010 Port ativo  out  1  high whenever state is not INICIAL.
REQ-011 Port pronto  out  1  one-cycle pulse marking end of playback.
REQ-012 Port db_estado  out  4  current state encoding, for the hexa7seg debug display.

Function
REQ-013 The FSM SHALL have states INICIAL=0, PREPARA=1, ACENDE=2, APAGA=3, PROXIMO=4, FIM=5; db_estado SHALL equal the current state code, and codes 6..15 SHALL return to INICIAL on the next edge.
REQ-014 INICIAL: endereco held at 0, leds=0, timer=0; iniciar=1 SHALL load rodada into internal rodada_reg and go to PREPARA.
REQ-015 PREPARA: one cycle, timer cleared, endereco=0, leds=0, then ACENDE.
REQ-016 ACENDE: leds SHALL equal dado combinationally; timer increments each cycle; at timer==T_ACESO-1 it clears and goes to APAGA (exactly T_ACESO cycles in ACENDE).
REQ-017 APAGA: leds=0; timer increments; at timer==T_APAGADO-1 it clears and goes to FIM if endereco==rodada_reg, else PROXIMO (exactly T_APAGADO cycles).
REQ-018 PROXIMO: one cycle, leds=0; endereco SHALL increment by 1 on leaving, then ACENDE.
REQ-019 FIM: one cycle, pronto=1, leds=0, then INICIAL, where endereco returns to 0.
REQ-020 pronto SHALL be 1 only in FIM; ativo SHALL be 1 in states 1..5.
REQ-021 iniciar SHALL be ignored outside INICIAL, with no restart and no effect on timing.
REQ-022 Changes on rodada after the start cycle SHALL be ignored; only rodada_reg is used.
REQ-023 endereco SHALL never wrap: with rodada_reg=15 the last address shown is 15, then FIM.
REQ-024 The timer SHALL be 16 bits unsigned, and comparisons SHALL use T-1 so that T=1 gives one cycle.
REQ-025 dado=0 in ACENDE SHALL still consume the full T_ACESO cycles (leds=0 during that time).
REQ-026 Timing: with iniciar sampled at edge 0, the first ACENDE cycle is cycle 2 and FIM is cycle 2+(r+1)*(T_ACESO+T_APAGADO)+r, where r=rodada_reg.

Reset
REQ-027 reset=1 at any rising edge SHALL force INICIAL, timer=0, endereco=0, rodada_reg=0 on that edge, overriding iniciar and all transitions.
REQ-028 After reset: leds=0, pronto=0, ativo=0, endereco=0, db_estado=0.
REQ-029 Reset mid-playback SHALL abort with no pronto pulse; a new iniciar after release restarts from address 0.

Verification (T_ACESO=3, T_APAGADO=2)
REQ-030 Apply reset for 2 cycles -> db_estado=0, leds=0, pronto=0, ativo=0, endereco=0.
REQ-031 Set rodada=0 and mem[0]=0001, then pulse iniciar -> leds=0001 for cycles 2..4, 0 for cycles 5..6, pronto=1 only in cycle 7, ativo=1 for cycles 1..7.
REQ-032 Set rodada=2 and mem={0001,0010,0100}, then start -> leds shows 0001, 0010, 0100 with 3 lit and 2 dark cycles each; endereco steps 0,1,2; pronto in cycle 19.
REQ-033 Use the scenario of REQ-032, pulse iniciar and change rodada to 5 during ACENDE -> timing, addresses and pronto cycle are unchanged from REQ-032.
REQ-034 Use the scenario of REQ-032 and assert reset in the second ACENDE -> INICIAL next edge, leds=0, no pronto; restart then plays from address 0.
REQ-035 Set rodada=15 -> addresses 0..15 shown in order, no wrap to 0 before FIM, pronto in cycle 2+16*5+15=97.
